// File: rtl/raw_data_out_packer.sv
// raw_data_out_packer
//   Drains encoded sub-words (with slot index) from the raw_data_out FIFO and
//   packs up to WORDS of them into one wide beat with per-slot keep. The beat
//   is offered on a valid/ready stream. A partial beat closes when:
//     - the incoming index hits a slot that is already filled (wrap or repeat),
//     - flush is requested, or
//     - the accumulator has sat idle for TIMEOUT cycles.
//
// Ports
//   clk                      clock, all state on rising edge
//   reset                    asynchronous active-high reset
//   raw_data_out_fifo_empty  FIFO empty; head entry valid when low (FWFT)
//   raw_data_out_fifo_dout   head sub-word
//   raw_data_out_index_dout  head slot index
//   raw_data_out_fifo_pop    pop head entry this cycle
//   flush                    single-cycle request to emit a partial beat
//   m_tdata                  slot k at bits [k*WORD_W +: WORD_W]
//   m_tkeep                  bit k set when slot k holds data
//   m_tvalid / m_tready      output stream handshake
//   beat_count               beats accepted by the sink, wraps at 2^16
//   dup_index_err            sticky: a repeated/wrapped index closed a beat early
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | popping sub-words into the accumulator, deciding when to close
// EMIT    | output register holds a beat, waiting for m_tready
module raw_data_out_packer #(
    parameter int  WORD_W  = 32,
    parameter int  WORDS   = 4,
    parameter int  TIMEOUT = 64,
    localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    raw_data_out_fifo_empty,
    input  logic [WORD_W-1:0]       raw_data_out_fifo_dout,
    input  logic [IDX_W-1:0]        raw_data_out_index_dout,
    output logic                    raw_data_out_fifo_pop,
    input  logic                    flush,
    output logic [WORD_W*WORDS-1:0] m_tdata,
    output logic [WORDS-1:0]        m_tkeep,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [15:0]             beat_count,
    output logic                    dup_index_err
);

    localparam int               CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(WORDS - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [WORD_W*WORDS-1:0] accum_q;
    logic [WORDS-1:0]        keep_q;
    logic [CNT_W-1:0]        idle_q;

    logic                    in_collect;
    logic                    has_data;
    logic                    close_req;
    logic                    head_dup;
    logic                    pop_ok;
    logic                    dup_take;
    logic                    emit;
    logic [WORD_W*WORDS-1:0] accum_m;
    logic [WORDS-1:0]        keep_m;

    // Reset gates the pop so the FIFO is never drained while reset is held.
    assign in_collect = (state_q == COLLECT) && !reset;
    assign has_data   = |keep_q;
    assign close_req  = in_collect && has_data &&
                        (flush || ((TIMEOUT != 0) && (idle_q == IDLE_LAST)));
    assign head_dup   = keep_q[raw_data_out_index_dout];
    // Flush/timeout win over the head word; a filled slot means the head word
    // belongs to the next beat, so it stays in the FIFO.
    assign pop_ok     = in_collect && !raw_data_out_fifo_empty && !close_req && !head_dup;
    assign dup_take   = in_collect && !raw_data_out_fifo_empty && !close_req && head_dup;
    assign emit       = close_req || dup_take ||
                        (pop_ok && (raw_data_out_index_dout == LAST_SLOT));

    // Accumulator with this cycle's word merged in, so a last-slot word goes
    // straight into the output register on the same edge.
    always_comb begin
        accum_m = accum_q;
        keep_m  = keep_q;
        for (int k = 0; k < WORDS; k++) begin
            if (pop_ok && (raw_data_out_index_dout == IDX_W'(k))) begin
                accum_m[k*WORD_W +: WORD_W] = raw_data_out_fifo_dout;
                keep_m[k]                   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (emit)     state_d = EMIT;
            EMIT:    if (m_tready) state_d = COLLECT;
            default:               state_d = COLLECT;
        endcase
    end

    always_comb begin
        raw_data_out_fifo_pop = pop_ok;
        m_tvalid              = (state_q == EMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accum_q       <= '0;
            keep_q        <= '0;
            idle_q        <= '0;
            m_tdata       <= '0;
            m_tkeep       <= '0;
            beat_count    <= '0;
            dup_index_err <= 1'b0;
        end else begin
            if (emit) begin
                m_tdata <= accum_m;
                m_tkeep <= keep_m;
                accum_q <= '0;
                keep_q  <= '0;
            end else begin
                accum_q <= accum_m;
                keep_q  <= keep_m;
            end

            if (!in_collect || pop_ok || emit || !has_data) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + 1'b1;
            end

            if (m_tvalid && m_tready) begin
                beat_count <= beat_count + 16'd1;
            end

            if (dup_take) begin
                dup_index_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_raw_data_out_packer.sv
module tb_raw_data_out_packer;

    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         fifo_empty;
    logic [31:0]  fifo_dout;
    logic [1:0]   index_dout;
    logic         fifo_pop;
    logic         flush;
    logic [127:0] m_tdata;
    logic [3:0]   m_tkeep;
    logic         m_tvalid;
    logic         m_tready;
    logic [15:0]  beat_count;
    logic         dup_index_err;

    raw_data_out_packer #(.WORD_W(32), .WORDS(4), .TIMEOUT(TIMEOUT)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .raw_data_out_fifo_empty (fifo_empty),
        .raw_data_out_fifo_dout  (fifo_dout),
        .raw_data_out_index_dout (index_dout),
        .raw_data_out_fifo_pop   (fifo_pop),
        .flush                   (flush),
        .m_tdata                 (m_tdata),
        .m_tkeep                 (m_tkeep),
        .m_tvalid                (m_tvalid),
        .m_tready                (m_tready),
        .beat_count              (beat_count),
        .dup_index_err           (dup_index_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // FIFO contents: {index, word}
    logic [33:0] fifo_q[$];

    // Reference model: slots being filled, beat in flight, counters.
    logic [31:0] slot_w[4];
    bit          slot_v[4];
    logic [31:0] out_w[4];
    bit          out_v[4];
    bit          m_busy;
    bit          m_dup;
    int          m_idle;
    int          m_beats;

    // Observation bookkeeping
    int           cyc;
    int           last_pop_cyc;
    int           vr_cyc;
    bit           last_pop_obs;
    logic [127:0] acc_last_data;
    logic [3:0]   acc_last_keep;
    int           acc_words;
    int           popped;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            slot_w[k] = '0;
            slot_v[k] = 1'b0;
            out_w[k]  = '0;
            out_v[k]  = 1'b0;
        end
        m_busy  = 1'b0;
        m_dup   = 1'b0;
        m_idle  = 0;
        m_beats = 0;
    endtask

    // One cycle of the packing rules; returns whether the head word is consumed.
    task automatic model_eval(input bit e, input logic [1:0] ix, input logic [31:0] w,
                              input bit fl, input bit rdy, output bit ep);
        bit any;
        bit close;
        ep    = 1'b0;
        close = 1'b0;
        any   = slot_v[0] || slot_v[1] || slot_v[2] || slot_v[3];
        if (!m_busy) begin
            if (any && (fl || (m_idle == TIMEOUT - 1))) begin
                close = 1'b1;
            end else if (!e) begin
                if (slot_v[ix]) begin
                    close = 1'b1;
                    m_dup = 1'b1;
                end else begin
                    slot_w[ix] = w;
                    slot_v[ix] = 1'b1;
                    ep         = 1'b1;
                    if (ix == 2'd3) close = 1'b1;
                end
            end
            if (close || ep || !any) m_idle = 0;
            else                     m_idle = m_idle + 1;
            if (close) begin
                for (int k = 0; k < 4; k++) begin
                    out_w[k]  = slot_v[k] ? slot_w[k] : 32'd0;
                    out_v[k]  = slot_v[k];
                    slot_w[k] = '0;
                    slot_v[k] = 1'b0;
                end
                m_busy = 1'b1;
            end
        end else begin
            m_idle = 0;
            if (rdy) begin
                m_beats = (m_beats + 1) % 65536;
                m_busy  = 1'b0;
            end
        end
    endtask

    task automatic push(input logic [1:0] ix, input logic [31:0] w);
        fifo_q.push_back({ix, w});
    endtask

    task automatic step(input bit fl, input bit rdy, input bit stall);
        bit          e;
        bit          ep;
        logic [1:0]  ix;
        logic [31:0] w;
        @(negedge clk);
        e = stall || (fifo_q.size() == 0);
        if (!e) begin
            w  = fifo_q[0][31:0];
            ix = fifo_q[0][33:32];
        end else begin
            w  = $urandom;
            ix = 2'($urandom_range(0, 3));
        end
        fifo_empty = e;
        fifo_dout  = w;
        index_dout = ix;
        flush      = fl;
        m_tready   = rdy;
        #1;
        check("tvalid", m_tvalid, m_busy);
        if (m_busy) begin
            check("tdata", m_tdata, {out_w[3], out_w[2], out_w[1], out_w[0]});
            check("tkeep", m_tkeep, {out_v[3], out_v[2], out_v[1], out_v[0]});
        end
        check("beat_count", beat_count, 16'(m_beats));
        check("dup_err", dup_index_err, m_dup);
        model_eval(e, ix, w, fl, rdy, ep);
        check("pop", fifo_pop, ep);
        last_pop_obs = fifo_pop;
        if (m_tvalid && vr_cyc < 0) vr_cyc = cyc;
        if (m_tvalid && rdy) begin
            acc_last_data = m_tdata;
            acc_last_keep = m_tkeep;
            acc_words     = acc_words + $countones(m_tkeep);
        end
        if (fifo_pop && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            popped++;
            last_pop_cyc = cyc;
        end
        cyc++;
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        index_dout = '0;
        flush      = 1'b0;
        m_tready   = 1'b0;
        cyc        = 0;
        vr_cyc     = -1;
        acc_words  = 0;
        popped     = 0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tkeep", m_tkeep, 0);
        check("rst_pop", fifo_pop, 0);
        check("rst_count", beat_count, 0);
        check("rst_dup", dup_index_err, 0);
        @(negedge clk);
        reset = 1'b0;

        // Full beat, in-order indices
        push(2'd0, 32'hA000_0000);
        push(2'd1, 32'hA111_1111);
        push(2'd2, 32'hA222_2222);
        push(2'd3, 32'hA333_3333);
        vr_cyc = -1;
        repeat (6) step(1'b0, 1'b1, 1'b0);
        check("full_data", acc_last_data, {32'hA333_3333, 32'hA222_2222, 32'hA111_1111, 32'hA000_0000});
        check("full_keep", acc_last_keep, 4'hF);
        check("full_latency", vr_cyc - last_pop_cyc, 1);
        check("full_count", beat_count, 16'd1);

        // Async reset while a beat is waiting
        push(2'd0, 32'h1);
        push(2'd1, 32'h2);
        push(2'd2, 32'h3);
        push(2'd3, 32'h4);
        push(2'd0, 32'h5);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        check("pre_rst_valid", m_tvalid, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_tvalid", m_tvalid, 0);
        check("arst_count", beat_count, 0);
        check("arst_pop", fifo_pop, 0);
        @(negedge clk);
        reset      = 1'b0;
        fifo_empty = 1'b1;
        fifo_q.delete();
        model_reset();

        // Index wrap closes a beat early
        push(2'd0, 32'hB000_0000);
        push(2'd1, 32'hB111_1111);
        push(2'd0, 32'hC000_0000);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        check("wrap_data", acc_last_data, {64'd0, 32'hB111_1111, 32'hB000_0000});
        check("wrap_keep", acc_last_keep, 4'h3);
        check("wrap_dup", dup_index_err, 1);
        step(1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        check("wrap_next_data", acc_last_data, {96'd0, 32'hC000_0000});
        check("wrap_next_keep", acc_last_keep, 4'h1);

        // Backpressure
        push(2'd0, 32'hD000_0000);
        push(2'd1, 32'hD111_1111);
        push(2'd2, 32'hD222_2222);
        push(2'd3, 32'hD333_3333);
        push(2'd1, 32'hE111_1111);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("bp_hold_pop", last_pop_obs, 0);
            check("bp_hold_data", m_tdata, {32'hD333_3333, 32'hD222_2222, 32'hD111_1111, 32'hD000_0000});
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("bp_resume_pop", last_pop_obs, 1);
        check("bp_count", beat_count, 16'd3);
        step(1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        check("bp_tail_keep", acc_last_keep, 4'h2);

        // Flush of a partial beat
        push(2'd2, 32'hF222_2222);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        check("flush_keep", acc_last_keep, 4'h4);
        check("flush_data", acc_last_data, {32'd0, 32'hF222_2222, 64'd0});

        // Idle timeout
        push(2'd2, 32'h9222_2222);
        step(1'b0, 1'b1, 1'b0);
        vr_cyc = -1;
        n = 0;
        while (vr_cyc < 0 && n < 200) begin
            step(1'b0, 1'b1, 1'b0);
            n++;
        end
        check("timeout_delay", vr_cyc - last_pop_cyc, TIMEOUT + 1);
        check("timeout_keep", acc_last_keep, 4'h4);

        // Flush with nothing accumulated
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("empty_flush_valid", m_tvalid, 0);
        check("empty_flush_count", beat_count, 16'd6);

        // Random traffic against the model
        acc_words = 0;
        popped    = 0;
        for (int i = 0; i < 10000; i++) push(2'($urandom_range(0, 3)), $urandom);
        n = 0;
        while (fifo_q.size() != 0 && n < 60000) begin
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 25);
            n++;
        end
        n = 0;
        while ((m_busy || slot_v[0] || slot_v[1] || slot_v[2] || slot_v[3]) && n < 100) begin
            step(1'b1, 1'b1, 1'b0);
            n++;
        end
        step(1'b0, 1'b1, 1'b0);
        check("rand_fifo_drained", fifo_q.size(), 0);
        check("rand_popped", popped, 10000);
        check("rand_words_out", acc_words, 10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
